pkg_chip: RTL and testbench
===========================

Name: pkg_chip

Overview:
- Chip-data packer; sits directly downstream of the package arbiter.
- On a one-cycle fire_pchip pulse it drains exactly PKT_LEN words from the chip buffer (pcbuf).
- It frames them as header, sequence, payload and checksum bytes onto a valid/ready byte stream toward the TX path.
- It then returns a one-cycle done_pchip pulse to the arbiter.

Parameters:
- PKT_LEN, 16, payload bytes per packet (legal range 1..255).
- HDR_BYTE, 8'hA5, constant first byte of every packet.

Ports:
- clk_sys  in  1  system clock. Only clock in the block.
- rst  in  1  asynchronous reset, active-high.
- fire_pchip  in  1  start pulse from the arbiter.
- done_pchip  out  1  one-cycle pulse after the last packet byte is accepted.
- pcbuf_empty  in  1  chip buffer empty flag.
- pcbuf_rd  out  1  chip buffer read strobe. Data appears on pcbuf_q the next cycle.
- pcbuf_q  in  8  chip buffer read data.
- pkt_data  out  8  packet byte.
- pkt_vld  out  1  pkt_data valid.
- pkt_rdy  in  1  downstream accepts the byte when pkt_vld & pkt_rdy.
- pkt_sof  out  1  marks the header byte. Qualified by pkt_vld.
- pkt_eof  out  1  marks the last byte. Qualified by pkt_vld.
- busy  out  1  high in every state except S_IDLE.

Behaviour:
- Clock and reset: single clock clk_sys. Reset rst is asynchronous and active-high.
- Reset values: all outputs 0, state S_IDLE, seq_cnt 0, byte_cnt 0, csum 0.

State machine (registered state, 3 bits):
- S_IDLE:
  - fire_pchip=1 -> S_HEAD. Also clears csum and byte_cnt.
  - Otherwise stay.
- S_HEAD:
  - pkt_data=HDR_BYTE, pkt_vld=1, pkt_sof=1.
  - On handshake -> S_SEQ.
- S_SEQ:
  - pkt_data=seq_cnt, pkt_vld=1.
  - On handshake: csum += seq_cnt, then -> S_READ.
- S_READ:
  - pcbuf_rd = ~pcbuf_empty. pkt_vld=0.
  - If pcbuf_rd=1 -> S_LOAD. Otherwise stay (stall indefinitely while empty).
- S_LOAD:
  - Capture pcbuf_q into the output register. csum += pcbuf_q.
  - byte_cnt += 1, then -> S_PAY.
- S_PAY:
  - pkt_vld=1 with the captured byte.
  - On handshake: if byte_cnt==PKT_LEN -> S_CSUM, else -> S_READ.
- S_CSUM:
  - pkt_data=csum, pkt_vld=1, pkt_eof=1.
  - On handshake -> S_DONE.
- S_DONE:
  - done_pchip=1 for exactly one cycle. seq_cnt += 1.
  - -> S_IDLE.
- Illegal state -> S_IDLE.

Handshake rules:
- pkt_data, pkt_sof and pkt_eof are held stable while pkt_vld=1 and pkt_rdy=0.
- pkt_vld never drops without a handshake.
- pcbuf_rd is asserted only in S_READ and never when pcbuf_empty=1. This gives at most one outstanding read, so no holding FIFO is needed.

Arithmetic:
- csum: 8-bit sum mod 256 of the sequence byte and all payload bytes. The header byte is excluded.
- seq_cnt: 8 bits, wraps 255 -> 0.
- byte_cnt: 8 bits.

Boundary conditions:
- fire_pchip while busy=1: ignored, no effect.
- fire_pchip in the same cycle as done_pchip: ignored. The block is in S_DONE, not S_IDLE.
- pcbuf goes empty mid-packet: stall in S_READ. The packet resumes when data arrives. No data loss, no duplicate read.
- pkt_rdy held high: each payload byte takes 3 cycles (READ, LOAD, PAY).
- Minimum packet time is PKT_LEN*3 + 4 cycles, plus 1 cycle for S_DONE.
- PKT_LEN=1: header, seq, 1 payload byte, csum. eof is on the csum byte.
- Reset mid-packet: immediate return to reset values. No done_pchip. The partial packet is abandoned and seq_cnt returns to 0.

Optional Feature:
- Macro: PKG_CHIP_CSUM_EN.
- Defined: behaviour as above. S_CSUM is present and pkt_eof is on the checksum byte.
- Undefined:
  - No checksum byte and no csum register; S_CSUM is removed.
  - pkt_eof=1 on the last payload byte.
  - S_PAY goes directly to S_DONE on the handshake when byte_cnt==PKT_LEN.

Decomposition:
- Shared package pkg_defs: state encodings S_IDLE..S_DONE (3'h0..3'h7), default HDR_BYTE, default PKT_LEN. The package assembler pkg_app reuses the same framing constants.
- One natural sub-module: pkg_csum, an 8-bit accumulator with clear and add-enable, instantiated only under PKG_CHIP_CSUM_EN.
- Framing FSM and counters stay in pkg_chip.

Test Plan:
- Reset/basic:
  - Stimulus: PKT_LEN=4, pcbuf preloaded 01,02,03,04, pkt_rdy=1, pulse fire_pchip.
  - Response: stream A5,00,01,02,03,04,0A. sof on A5, eof on 0A. done_pchip pulses once, 1 cycle after the 0A handshake.
- Back-to-back sequence:
  - Stimulus: two packets of payload 00,00,00,00.
  - Response: seq bytes 00 then 01, checksums 00 then 01. Run 256 packets and check seq wraps to 00.
- Backpressure:
  - Stimulus: pkt_rdy toggled randomly.
  - Response: pkt_data, pkt_sof and pkt_eof stable while vld&~rdy. Output byte sequence identical to the rdy=1 case.
- Empty stall:
  - Stimulus: pcbuf_empty=1 for 20 cycles after the 2nd payload byte.
  - Response: pcbuf_rd=0 throughout the stall, pkt_vld=0, no duplicate byte. The packet completes correctly.
- Spurious fire and reset:
  - Stimulus: fire_pchip while busy. Then rst asserted mid-payload.
  - Response: the extra fire is ignored. After rst: all outputs 0, no done_pchip, next packet's seq=00.
- Macro off (PKG_CHIP_CSUM_EN undefined):
  - Stimulus: same as the reset/basic case.
  - Response: stream A5,00,01,02,03,04 with eof on 04. done_pchip pulses 1 cycle after that handshake.

Source files
------------

// File: rtl/pkg_defs.sv
// ============================================================================
//  Module      : pkg_defs (package)
//  Description : Shared framing constants for the chip-data packer and the
//                package assembler: FSM state encodings, default header byte
//                and default payload length.
//  Optional    : none in this file (PKG_CHIP_CSUM_EN is consumed by pkg_chip)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pkg_defs;

    // Framing FSM encodings (3-bit registered state)
    localparam logic [2:0] S_IDLE = 3'h0;
    localparam logic [2:0] S_HEAD = 3'h1;
    localparam logic [2:0] S_SEQ  = 3'h2;
    localparam logic [2:0] S_READ = 3'h3;
    localparam logic [2:0] S_LOAD = 3'h4;
    localparam logic [2:0] S_PAY  = 3'h5;
    localparam logic [2:0] S_CSUM = 3'h6;
    localparam logic [2:0] S_DONE = 3'h7;

    // Framing defaults shared with the package assembler
    localparam int         PKT_LEN_DEFAULT  = 16;
    localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

endpackage

`default_nettype wire

// File: rtl/pkg_csum.sv
// ============================================================================
//  Module      : pkg_csum
//  Description : 8-bit modulo-256 accumulator with synchronous clear and
//                add-enable. Clear has priority over add.
//  Ports       : clk    - clock
//                rst    - asynchronous active-high reset
//                clr    - zero the accumulator
//                add_en - add din into the accumulator
//                din    - addend
//                sum    - current accumulator value
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pkg_csum (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       add_en,
    input  logic [7:0] din,
    output logic [7:0] sum
);

    logic [7:0] r_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum <= 8'h00;
        end else if (clr) begin
            r_sum <= 8'h00;
        end else if (add_en) begin
            r_sum <= r_sum + din;
        end
    end

    assign sum = r_sum;

endmodule

`default_nettype wire

// File: rtl/pkg_chip.sv
// ============================================================================
//  Module      : pkg_chip
//  Description : Chip-data packer. On a fire_pchip pulse it drains PKT_LEN
//                bytes from the chip buffer and emits a framed packet
//                (header, sequence, payload[, checksum]) on a valid/ready
//                byte stream, then pulses done_pchip for one cycle.
//  Optional    : `define PKG_CHIP_CSUM_EN adds a trailing checksum byte
//                (sum mod 256 of sequence and payload bytes). Without it the
//                packet ends on the last payload byte.
//  Ports       : clk_sys     - system clock
//                rst         - asynchronous active-high reset
//                fire_pchip  - start pulse (ignored unless idle)
//                done_pchip  - one-cycle completion pulse
//                pcbuf_empty - chip buffer empty flag
//                pcbuf_rd    - chip buffer read strobe (data next cycle)
//                pcbuf_q     - chip buffer read data
//                pkt_data    - packet byte
//                pkt_vld     - pkt_data valid
//                pkt_rdy     - downstream ready
//                pkt_sof     - header byte marker
//                pkt_eof     - last byte marker
//                busy        - high whenever not idle
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pkg_chip
    import pkg_defs::*;
#(
    parameter int         PKT_LEN  = PKT_LEN_DEFAULT,
    parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEFAULT
) (
    input  logic       clk_sys,
    input  logic       rst,
    input  logic       fire_pchip,
    output logic       done_pchip,
    input  logic       pcbuf_empty,
    output logic       pcbuf_rd,
    input  logic [7:0] pcbuf_q,
    output logic [7:0] pkt_data,
    output logic       pkt_vld,
    input  logic       pkt_rdy,
    output logic       pkt_sof,
    output logic       pkt_eof,
    output logic       busy
);

    localparam logic [7:0] C_PKT_LEN = 8'(PKT_LEN);

    logic [2:0] r_state;
    logic [7:0] r_seq_cnt;
    logic [7:0] r_byte_cnt;
    logic [7:0] r_pay;
    logic       w_hs;
    logic       w_last_pay;

    assign w_hs       = pkt_vld & pkt_rdy;
    assign w_last_pay = (r_byte_cnt == C_PKT_LEN);

`ifdef PKG_CHIP_CSUM_EN
    logic [7:0] w_csum;
    logic       w_csum_clr;
    logic       w_csum_add;
    logic [7:0] w_csum_din;

    // Sequence byte is summed on its handshake; payload bytes as they are
    // captured from the buffer. The header is never summed.
    assign w_csum_clr = (r_state == S_IDLE) & fire_pchip;
    assign w_csum_add = ((r_state == S_SEQ) & w_hs) | (r_state == S_LOAD);
    assign w_csum_din = (r_state == S_SEQ) ? r_seq_cnt : pcbuf_q;

    pkg_csum u_csum (
        .clk    (clk_sys),
        .rst    (rst),
        .clr    (w_csum_clr),
        .add_en (w_csum_add),
        .din    (w_csum_din),
        .sum    (w_csum)
    );
`endif

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_seq_cnt  <= 8'h00;
            r_byte_cnt <= 8'h00;
            r_pay      <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (fire_pchip) begin
                        r_state    <= S_HEAD;
                        r_byte_cnt <= 8'h00;
                    end
                end
                S_HEAD: begin
                    if (w_hs) r_state <= S_SEQ;
                end
                S_SEQ: begin
                    if (w_hs) r_state <= S_READ;
                end
                S_READ: begin
                    // Read strobe equals ~pcbuf_empty here, so leaving READ
                    // always means exactly one read is in flight.
                    if (!pcbuf_empty) r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_pay      <= pcbuf_q;
                    r_byte_cnt <= r_byte_cnt + 8'h01;
                    r_state    <= S_PAY;
                end
                S_PAY: begin
                    if (w_hs) begin
                        if (w_last_pay) begin
`ifdef PKG_CHIP_CSUM_EN
                            r_state <= S_CSUM;
`else
                            r_state <= S_DONE;
`endif
                        end else begin
                            r_state <= S_READ;
                        end
                    end
                end
`ifdef PKG_CHIP_CSUM_EN
                S_CSUM: begin
                    if (w_hs) r_state <= S_DONE;
                end
`endif
                S_DONE: begin
                    r_seq_cnt <= r_seq_cnt + 8'h01;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode purely from state and held registers, so they stay
    // stable for as long as the state waits on pkt_rdy.
    always_comb begin
        pkt_data   = 8'h00;
        pkt_vld    = 1'b0;
        pkt_sof    = 1'b0;
        pkt_eof    = 1'b0;
        pcbuf_rd   = 1'b0;
        done_pchip = 1'b0;
        case (r_state)
            S_HEAD: begin
                pkt_data = HDR_BYTE;
                pkt_vld  = 1'b1;
                pkt_sof  = 1'b1;
            end
            S_SEQ: begin
                pkt_data = r_seq_cnt;
                pkt_vld  = 1'b1;
            end
            S_READ: begin
                pcbuf_rd = ~pcbuf_empty;
            end
            S_PAY: begin
                pkt_data = r_pay;
                pkt_vld  = 1'b1;
`ifndef PKG_CHIP_CSUM_EN
                pkt_eof  = w_last_pay;
`endif
            end
`ifdef PKG_CHIP_CSUM_EN
            S_CSUM: begin
                pkt_data = w_csum;
                pkt_vld  = 1'b1;
                pkt_eof  = 1'b1;
            end
`endif
            S_DONE: begin
                done_pchip = 1'b1;
            end
            default: begin
                pkt_data = 8'h00;
            end
        endcase
    end

    assign busy = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_pkg_chip.sv
// ============================================================================
//  Module      : tb_pkg_chip
//  Description : Self-checking bench for pkg_chip with PKT_LEN=4. Expected
//                streams come from a small framing model that follows the
//                PKG_CHIP_CSUM_EN setting of the build.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pkg_chip;

    localparam int LEN = 4;

    logic       clk_sys = 1'b0;
    logic       rst = 1'b1;
    logic       fire_pchip = 1'b0;
    logic       done_pchip;
    logic       pcbuf_empty;
    logic       pcbuf_rd;
    logic [7:0] pcbuf_q = 8'h00;
    logic [7:0] pkt_data;
    logic       pkt_vld;
    logic       pkt_rdy = 1'b1;
    logic       pkt_sof;
    logic       pkt_eof;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    pkg_chip #(.PKT_LEN(LEN), .HDR_BYTE(8'hA5)) dut (
        .clk_sys     (clk_sys),
        .rst         (rst),
        .fire_pchip  (fire_pchip),
        .done_pchip  (done_pchip),
        .pcbuf_empty (pcbuf_empty),
        .pcbuf_rd    (pcbuf_rd),
        .pcbuf_q     (pcbuf_q),
        .pkt_data    (pkt_data),
        .pkt_vld     (pkt_vld),
        .pkt_rdy     (pkt_rdy),
        .pkt_sof     (pkt_sof),
        .pkt_eof     (pkt_eof),
        .busy        (busy)
    );

    always #5 clk_sys = ~clk_sys;

    // ---------------- chip buffer model ----------------
    logic [7:0] mem [0:4095];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       flush = 1'b0;

    assign pcbuf_empty = (rd_ptr == wr_ptr);

    always @(posedge clk_sys) begin
        if (flush) begin
            rd_ptr <= wr_ptr;
        end else if (pcbuf_rd) begin
            pcbuf_q <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + 1;
        end
    end

    // ---------------- downstream ready driver ----------------
    logic bp_en = 1'b0;
    always @(posedge clk_sys) begin
        #1;
        pkt_rdy = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // ---------------- stream monitor ----------------
    logic [7:0] cap_data [0:4095];
    logic       cap_sof  [0:4095];
    logic       cap_eof  [0:4095];
    int         cap_cnt    = 0;
    int         done_cnt   = 0;
    int         cyc        = 0;
    int         hs_cyc     = 0;
    int         done_gap   = 0;
    int         stable_err = 0;
    int         rd_err     = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic       prev_sof   = 1'b0;
    logic       prev_eof   = 1'b0;

    always @(negedge clk_sys) begin
        cyc <= cyc + 1;
        if (!rst && prev_stall &&
            (!pkt_vld || pkt_data !== prev_data || pkt_sof !== prev_sof || pkt_eof !== prev_eof))
            stable_err <= stable_err + 1;
        prev_stall <= pkt_vld && !pkt_rdy && !rst;
        prev_data  <= pkt_data;
        prev_sof   <= pkt_sof;
        prev_eof   <= pkt_eof;
        if (pkt_vld && pkt_rdy && cap_cnt < 4096) begin
            cap_data[cap_cnt] <= pkt_data;
            cap_sof[cap_cnt]  <= pkt_sof;
            cap_eof[cap_cnt]  <= pkt_eof;
            cap_cnt           <= cap_cnt + 1;
            hs_cyc            <= cyc;
        end
        if (done_pchip) begin
            done_cnt <= done_cnt + 1;
            done_gap <= cyc - hs_cyc;
        end
        if (pcbuf_rd && pcbuf_empty) rd_err <= rd_err + 1;
    end

    // ---------------- framing model ----------------
    logic [7:0] pay      [LEN];
    logic [7:0] exp_data [LEN+3];
    int         exp_n;
    logic [7:0] exp_seq = 8'h00;

    function automatic void build_exp(input logic [7:0] seq);
        exp_data[0] = 8'hA5;
        exp_data[1] = seq;
        for (int i = 0; i < LEN; i++) exp_data[2+i] = pay[i];
`ifdef PKG_CHIP_CSUM_EN
        begin
            logic [7:0] s;
            s = seq;
            for (int i = 0; i < LEN; i++) s = s + pay[i];
            exp_data[LEN+2] = s;
            exp_n = LEN + 3;
        end
`else
        exp_n = LEN + 2;
`endif
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic push_pay(input int from, input int upto);
        for (int i = from; i < upto; i++) begin
            mem[wr_ptr] = pay[i];
            wr_ptr      = wr_ptr + 1;
        end
    endtask

    task automatic pulse_fire();
        @(posedge clk_sys); #1;
        fire_pchip = 1'b1;
        @(posedge clk_sys); #1;
        fire_pchip = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0);
        int t;
        t = 0;
        while (done_cnt == d0 && t < 500) begin
            @(posedge clk_sys); #1;
            t++;
        end
        n_checks++;
        if (done_cnt == d0) begin
            n_fail++;
            $display("FAIL %s_timeout: done_pchip count %0d, required %0d", tag, done_cnt, d0 + 1);
        end
    endtask

    task automatic wait_cap(input string tag, input int target);
        int t;
        t = 0;
        while (cap_cnt < target && t < 500) begin
            @(posedge clk_sys); #1;
            t++;
        end
        n_checks++;
        if (cap_cnt < target) begin
            n_fail++;
            $display("FAIL %s_wait: accepted bytes %0d, required %0d", tag, cap_cnt, target);
        end
    endtask

    task automatic apply_reset();
        @(posedge clk_sys); #1;
        rst   = 1'b1;
        flush = 1'b1;
        @(posedge clk_sys); #1;
        @(posedge clk_sys); #1;
        rst   = 1'b0;
        flush = 1'b0;
        exp_seq = 8'h00;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk_sys);
        n_checks++;
        if ({done_pchip, pcbuf_rd, pkt_data, pkt_vld, pkt_sof, pkt_eof, busy} !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, required 0", {done_pchip, pcbuf_rd, pkt_data, pkt_vld, pkt_sof, pkt_eof, busy});
        end
        @(posedge clk_sys); #1;
        rst = 1'b0;
        @(negedge clk_sys);
        n_checks++;
        if ({done_pchip, pcbuf_rd, pkt_data, pkt_vld, pkt_sof, pkt_eof, busy} !== 14'h0) begin
            n_fail++;
            $display("FAIL idle_outputs: got %h, required 0", {done_pchip, pcbuf_rd, pkt_data, pkt_vld, pkt_sof, pkt_eof, busy});
        end
    endtask

    task automatic test_basic();
        int base, d0;
        pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03; pay[3] = 8'h04;
        build_exp(exp_seq);
        push_pay(0, LEN);
        base = cap_cnt; d0 = done_cnt;
        pulse_fire();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy: got %b, required 1", busy);
        end
        wait_done("basic", d0);
        exp_seq = exp_seq + 8'h01;
        n_checks++;
        if (cap_cnt - base !== exp_n) begin
            n_fail++;
            $display("FAIL basic_len: got %0d bytes, required %0d", cap_cnt - base, exp_n);
        end
        for (int i = 0; i < exp_n; i++) begin
            n_checks++;
            if (cap_data[base+i] !== exp_data[i] || cap_sof[base+i] !== (i == 0) || cap_eof[base+i] !== (i == exp_n-1)) begin
                n_fail++;
                $display("FAIL basic_byte%0d: got %h sof=%b eof=%b, required %h sof=%b eof=%b", i,
                         cap_data[base+i], cap_sof[base+i], cap_eof[base+i], exp_data[i], i == 0, i == exp_n-1);
            end
        end
        n_checks++;
        if (done_gap !== 1) begin
            n_fail++;
            $display("FAIL basic_done_latency: got %0d cycles, required 1", done_gap);
        end
        repeat (3) @(posedge clk_sys);
        #1;
        n_checks++;
        if (done_cnt - d0 !== 1) begin
            n_fail++;
            $display("FAIL basic_done_count: got %0d pulses, required 1", done_cnt - d0);
        end
    endtask

    task automatic test_back_to_back();
        int base, d0;
        apply_reset();
        for (int i = 0; i < LEN; i++) pay[i] = 8'h00;
        for (int p = 0; p < 257; p++) begin
            build_exp(exp_seq);
            push_pay(0, LEN);
            base = cap_cnt; d0 = done_cnt;
            pulse_fire();
            wait_done("b2b", d0);
            exp_seq = exp_seq + 8'h01;
            if (p == 0 || p == 1 || p == 256) begin
                n_checks++;
                if (cap_cnt - base !== exp_n) begin
                    n_fail++;
                    $display("FAIL b2b_pkt%0d_len: got %0d bytes, required %0d", p, cap_cnt - base, exp_n);
                end
                for (int i = 0; i < exp_n; i++) begin
                    n_checks++;
                    if (cap_data[base+i] !== exp_data[i] || cap_sof[base+i] !== (i == 0) || cap_eof[base+i] !== (i == exp_n-1)) begin
                        n_fail++;
                        $display("FAIL b2b_pkt%0d_byte%0d: got %h sof=%b eof=%b, required %h", p, i,
                                 cap_data[base+i], cap_sof[base+i], cap_eof[base+i], exp_data[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int base, d0, se0;
        pay[0] = 8'h3C; pay[1] = 8'hC3; pay[2] = 8'h5A; pay[3] = 8'hFF;
        build_exp(exp_seq);
        push_pay(0, LEN);
        base = cap_cnt; d0 = done_cnt; se0 = stable_err;
        bp_en = 1'b1;
        pulse_fire();
        wait_done("bp", d0);
        bp_en = 1'b0;
        exp_seq = exp_seq + 8'h01;
        n_checks++;
        if (stable_err - se0 !== 0) begin
            n_fail++;
            $display("FAIL bp_stability: got %0d unstable cycles, required 0", stable_err - se0);
        end
        n_checks++;
        if (cap_cnt - base !== exp_n) begin
            n_fail++;
            $display("FAIL bp_len: got %0d bytes, required %0d", cap_cnt - base, exp_n);
        end
        for (int i = 0; i < exp_n; i++) begin
            n_checks++;
            if (cap_data[base+i] !== exp_data[i] || cap_sof[base+i] !== (i == 0) || cap_eof[base+i] !== (i == exp_n-1)) begin
                n_fail++;
                $display("FAIL bp_byte%0d: got %h sof=%b eof=%b, required %h", i,
                         cap_data[base+i], cap_sof[base+i], cap_eof[base+i], exp_data[i]);
            end
        end
    endtask

    task automatic test_empty_stall();
        int base, d0, re0;
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
        build_exp(exp_seq);
        push_pay(0, 2);
        base = cap_cnt; d0 = done_cnt; re0 = rd_err;
        pulse_fire();
        wait_cap("stall", base + 4);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_sys);
            n_checks++;
            if (pcbuf_rd !== 1'b0 || pkt_vld !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_cycle%0d: got rd=%b vld=%b, required rd=0 vld=0", c, pcbuf_rd, pkt_vld);
            end
        end
        push_pay(2, LEN);
        wait_done("stall", d0);
        exp_seq = exp_seq + 8'h01;
        n_checks++;
        if (rd_err - re0 !== 0) begin
            n_fail++;
            $display("FAIL stall_rd_on_empty: got %0d reads, required 0", rd_err - re0);
        end
        n_checks++;
        if (cap_cnt - base !== exp_n) begin
            n_fail++;
            $display("FAIL stall_len: got %0d bytes, required %0d", cap_cnt - base, exp_n);
        end
        for (int i = 0; i < exp_n; i++) begin
            n_checks++;
            if (cap_data[base+i] !== exp_data[i] || cap_eof[base+i] !== (i == exp_n-1)) begin
                n_fail++;
                $display("FAIL stall_byte%0d: got %h eof=%b, required %h", i, cap_data[base+i], cap_eof[base+i], exp_data[i]);
            end
        end
    endtask

    task automatic test_spurious_fire();
        int base, d0, t;
        pay[0] = 8'h10; pay[1] = 8'h20; pay[2] = 8'h30; pay[3] = 8'h40;
        build_exp(exp_seq);
        push_pay(0, 2 * LEN);   // spare bytes would be consumed by a wrongly restarted packet
        base = cap_cnt; d0 = done_cnt;
        pulse_fire();
        wait_cap("spur", base + 3);
        pulse_fire();           // while busy
        t = 0;
        while (done_pchip !== 1'b1 && t < 500) begin
            @(posedge clk_sys); #1;
            t++;
        end
        n_checks++;
        if (done_pchip !== 1'b1) begin
            n_fail++;
            $display("FAIL spur_done_timeout: done_pchip %b, required 1", done_pchip);
        end
        fire_pchip = 1'b1;      // coincides with done_pchip
        @(posedge clk_sys); #1;
        fire_pchip = 1'b0;
        exp_seq = exp_seq + 8'h01;
        repeat (10) @(posedge clk_sys);
        #1;
        n_checks++;
        if (busy !== 1'b0 || done_cnt - d0 !== 1) begin
            n_fail++;
            $display("FAIL spur_ignored: got busy=%b done pulses=%0d, required busy=0 pulses=1", busy, done_cnt - d0);
        end
        n_checks++;
        if (cap_cnt - base !== exp_n) begin
            n_fail++;
            $display("FAIL spur_len: got %0d bytes, required %0d", cap_cnt - base, exp_n);
        end
        for (int i = 0; i < exp_n; i++) begin
            n_checks++;
            if (cap_data[base+i] !== exp_data[i]) begin
                n_fail++;
                $display("FAIL spur_byte%0d: got %h, required %h", i, cap_data[base+i], exp_data[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int base, d0;
        pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03; pay[3] = 8'h04;
        push_pay(0, LEN);
        base = cap_cnt; d0 = done_cnt;
        pulse_fire();
        wait_cap("rstmid", base + 3);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({done_pchip, pcbuf_rd, pkt_data, pkt_vld, pkt_sof, pkt_eof, busy} !== 14'h0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got %h, required 0", {done_pchip, pcbuf_rd, pkt_data, pkt_vld, pkt_sof, pkt_eof, busy});
        end
        @(posedge clk_sys); #1;
        flush = 1'b1;
        @(posedge clk_sys); #1;
        rst   = 1'b0;
        flush = 1'b0;
        exp_seq = 8'h00;
        repeat (5) @(posedge clk_sys);
        #1;
        n_checks++;
        if (done_cnt - d0 !== 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_no_done: got pulses=%0d busy=%b, required 0 and 0", done_cnt - d0, busy);
        end
        pay[0] = 8'h05; pay[1] = 8'h06; pay[2] = 8'h07; pay[3] = 8'h08;
        build_exp(exp_seq);
        push_pay(0, LEN);
        base = cap_cnt; d0 = done_cnt;
        pulse_fire();
        wait_done("rstmid", d0);
        n_checks++;
        if (cap_cnt - base !== exp_n) begin
            n_fail++;
            $display("FAIL rstmid_len: got %0d bytes, required %0d", cap_cnt - base, exp_n);
        end
        for (int i = 0; i < exp_n; i++) begin
            n_checks++;
            if (cap_data[base+i] !== exp_data[i] || cap_sof[base+i] !== (i == 0) || cap_eof[base+i] !== (i == exp_n-1)) begin
                n_fail++;
                $display("FAIL rstmid_byte%0d: got %h sof=%b eof=%b, required %h", i,
                         cap_data[base+i], cap_sof[base+i], cap_eof[base+i], exp_data[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_empty_stall();
        test_spurious_fire();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
